// File: rtl/wordle_pkg.sv
// Shared Wordle constants: word geometry, colour codes, letter codes and scorer state encodings.
// Imported by the scorer, keyboard, wordle_sm and the VGA renderer.
package wordle_pkg;

  localparam int unsigned WORD_LEN = 5;
  localparam int unsigned LETTER_W = 5;
  localparam int unsigned WORD_W   = WORD_LEN * LETTER_W;
  localparam int unsigned COLOR_W  = 2 * WORD_LEN;

  localparam logic [1:0] COL_NONE = 2'b00;
  localparam logic [1:0] COL_GRAY = 2'b01;
  localparam logic [1:0] COL_YEL  = 2'b10;
  localparam logic [1:0] COL_GRN  = 2'b11;

  localparam logic [LETTER_W-1:0] LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3;
  localparam logic [LETTER_W-1:0] LTR_E = 5'd4,  LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7;
  localparam logic [LETTER_W-1:0] LTR_I = 5'd8,  LTR_J = 5'd9,  LTR_K = 5'd10, LTR_L = 5'd11;
  localparam logic [LETTER_W-1:0] LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14, LTR_P = 5'd15;
  localparam logic [LETTER_W-1:0] LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19;
  localparam logic [LETTER_W-1:0] LTR_U = 5'd20, LTR_V = 5'd21, LTR_W = 5'd22, LTR_X = 5'd23;
  localparam logic [LETTER_W-1:0] LTR_Y = 5'd24, LTR_Z = 5'd25;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Letter at a 3-bit position; out-of-range positions read as zero.
  function automatic logic [LETTER_W-1:0] letter_at(input logic [WORD_W-1:0] w,
                                                     input logic [2:0]        idx);
    letter_at = '0;
    for (int k = 0; k < WORD_LEN; k++) begin
      if (idx == 3'(k)) letter_at = w[LETTER_W*k +: LETTER_W];
    end
  endfunction

endpackage

// File: rtl/wordle_scorer.sv
// Sequential Wordle guess scorer: a green pass over all positions, then a full
// (i,j) yellow scan that consumes target letters so duplicates score as in Wordle.
module wordle_scorer
  import wordle_pkg::*;
(
  input  logic               Clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [WORD_W-1:0]  guess,
  input  logic [WORD_W-1:0]  target,
  output logic               busy,
  output logic               done,
  output logic               win,
  output logic [COLOR_W-1:0] colors
);

  localparam logic [2:0] LastIdx = 3'(WORD_LEN - 1);

  logic [1:0]          state_q, state_d;
  logic [WORD_W-1:0]   g_q, g_d, t_q, t_d;
  logic [WORD_LEN-1:0] used_q, used_d;
  logic [2:0]          i_q, i_d, j_q, j_d;
  logic [COLOR_W-1:0]  colors_q, colors_d;
  logic                win_q, win_d;

  logic [LETTER_W-1:0] g_let, t_let_i, t_let_j;
  logic [1:0]          col_i;
  logic                used_j, all_green;

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    t_d      = t_q;
    used_d   = used_q;
    i_d      = i_q;
    j_d      = j_q;
    colors_d = colors_q;
    win_d    = win_q;

    g_let   = letter_at(g_q, i_q);
    t_let_i = letter_at(t_q, i_q);
    t_let_j = letter_at(t_q, j_q);
    col_i   = COL_NONE;
    used_j  = 1'b0;
    for (int k = 0; k < WORD_LEN; k++) begin
      if (i_q == 3'(k)) col_i = colors_q[2*k +: 2];
      if (j_q == 3'(k)) used_j = used_q[k];
    end

    case (state_q)
      IDLE: begin
        if (Start) begin
          g_d      = guess;
          t_d      = target;
          colors_d = '0;
          win_d    = 1'b0;
          used_d   = '0;
          i_d      = '0;
          j_d      = '0;
          state_d  = GREEN;
        end
      end
      GREEN: begin
        if (g_let == t_let_i) begin
          for (int k = 0; k < WORD_LEN; k++) begin
            if (i_q == 3'(k)) begin
              colors_d[2*k +: 2] = COL_GRN;
              used_d[k]          = 1'b1;
            end
          end
        end
        if (i_q == LastIdx) begin
          i_d     = '0;
          j_d     = '0;
          state_d = YELLOW;
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      YELLOW: begin
        // Lowest unused matching target letter wins; a scored position ignores later j.
        if (col_i == COL_NONE && !used_j && g_let == t_let_j) begin
          col_i = COL_YEL;
          for (int k = 0; k < WORD_LEN; k++) begin
            if (j_q == 3'(k)) used_d[k] = 1'b1;
          end
        end
        if (j_q == LastIdx && col_i == COL_NONE) col_i = COL_GRAY;
        for (int k = 0; k < WORD_LEN; k++) begin
          if (i_q == 3'(k)) colors_d[2*k +: 2] = col_i;
        end
        if (j_q == LastIdx) begin
          j_d = '0;
          if (i_q == LastIdx) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + 3'd1;
          end
        end else begin
          j_d = j_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    all_green = 1'b1;
    for (int k = 0; k < WORD_LEN; k++) begin
      if (colors_d[2*k +: 2] != COL_GRN) all_green = 1'b0;
    end
    if (state_q == YELLOW && state_d == DONE) win_d = all_green;
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      g_q      <= '0;
      t_q      <= '0;
      used_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      colors_q <= '0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      t_q      <= t_d;
      used_q   <= used_d;
      i_q      <= i_d;
      j_q      <= j_d;
      colors_q <= colors_d;
      win_q    <= win_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign win    = win_q;
  assign colors = colors_q;

endmodule
